// File: rtl/car_pkg.sv
// Shared types and defaults for the clock-and-reset controller.
package car_pkg;

   typedef enum logic [1:0] {StHold, StRelease, StDone} seq_state_e;

   localparam int unsigned DefNumCh      = 4;
   localparam int unsigned DefDivW       = 8;
   localparam int unsigned DefDivDefault = 2;
   localparam int unsigned DefSyncStages = 2;
   localparam int unsigned DefRstGap     = 4;

   // A programmed ratio of 0 behaves as divide-by-1.
   function automatic int unsigned norm_ratio(input int unsigned r);
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/car_div_ch.sv
// One channel's programmable divider: registered enable pulse, 50% toggle output and a
// shadowed ratio that is applied on a period boundary.
module car_div_ch
   import car_pkg::*;
#(
   parameter int unsigned DIV_W       = DefDivW,
   parameter int unsigned DIV_DEFAULT = DefDivDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ch_rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             div_load,
   output logic             clk_en,
   output logic             clk_div
);

   localparam logic [DIV_W-1:0] RatioRst = DIV_W'(norm_ratio(DIV_DEFAULT));
   localparam logic [DIV_W-1:0] One      = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d, ratio_q, ratio_d, shadow_q, shadow_d, ratio_eff;
   logic             pend_q, pend_d, pend_any;
   logic             clk_en_d, clk_div_d;
   logic             active, apply_imm, wrap;

   always_comb begin
      active    = ~ch_rst & en;
      // Idle or sitting at the start of a fresh period: a new ratio can take over at once.
      apply_imm = ~active | ((cnt_q == '0) & ~clk_en);
      shadow_d  = div_load ? div_ratio : shadow_q;
      pend_any  = div_load | pend_q;
      ratio_eff = (pend_any & apply_imm) ? DIV_W'(norm_ratio(32'(shadow_d))) : ratio_q;
      // >= rather than == so a ratio shrunk while idle cannot strand the counter.
      wrap      = active & (cnt_q >= ratio_eff - One);

      ratio_d   = ratio_q;
      pend_d    = pend_any;
      if (pend_any & (apply_imm | wrap)) begin
         ratio_d = DIV_W'(norm_ratio(32'(shadow_d)));
         pend_d  = 1'b0;
      end

      cnt_d     = cnt_q;
      clk_en_d  = 1'b0;
      clk_div_d = clk_div;
      if (active) begin
         if (wrap) begin
            cnt_d     = '0;
            clk_en_d  = 1'b1;
            clk_div_d = ~clk_div;
         end else begin
            cnt_d = cnt_q + One;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         ratio_q  <= RatioRst;
         shadow_q <= DIV_W'(DIV_DEFAULT);
         pend_q   <= 1'b0;
         clk_en   <= 1'b0;
         clk_div  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ratio_q  <= ratio_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         clk_en   <= clk_en_d;
         clk_div  <= clk_div_d;
      end
   end

endmodule

// File: rtl/car_ctrl.sv
// Clock-and-reset controller: reset-deassert synchroniser, staggered per-channel reset
// release sequencer and one divider per channel.
module car_ctrl
   import car_pkg::*;
#(
   parameter int unsigned NUM_CH      = DefNumCh,
   parameter int unsigned DIV_W       = DefDivW,
   parameter int unsigned DIV_DEFAULT = DefDivDefault,
   parameter int unsigned SYNC_STAGES = DefSyncStages,
   parameter int unsigned RST_GAP     = DefRstGap
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*DIV_W-1:0] div_ratio,
   input  logic [NUM_CH-1:0]       div_load,
   output logic [NUM_CH-1:0]       clk_en,
   output logic [NUM_CH-1:0]       clk_div,
   output logic [NUM_CH-1:0]       rst_out,
   output logic                    seq_done
);

   localparam int unsigned GapW = (RST_GAP > 1) ? $clog2(RST_GAP) : 1;
   localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [GapW-1:0] GapLoad = GapW'(RST_GAP - 1);
   localparam logic [IdxW-1:0] LastCh  = IdxW'(NUM_CH - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rst_sync;
   seq_state_e             state_q;
   logic [GapW-1:0]        gap_q;
   logic [IdxW-1:0]        idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
      end
   end

   assign rst_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StHold;
         gap_q    <= '0;
         idx_q    <= '0;
         rst_out  <= '1;
         seq_done <= 1'b0;
      end else begin
         unique case (state_q)
            StHold: begin
               if (!rst_sync) begin
                  rst_out[0] <= 1'b0;
                  gap_q      <= GapLoad;
                  idx_q      <= IdxW'(1);
                  if (NUM_CH == 1) begin
                     seq_done <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StRelease;
                  end
               end
            end
            StRelease: begin
               if (gap_q == '0) begin
                  rst_out[idx_q] <= 1'b0;
                  gap_q          <= GapLoad;
                  if (idx_q == LastCh) begin
                     seq_done <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     idx_q <= idx_q + IdxW'(1);
                  end
               end else begin
                  gap_q <= gap_q - GapW'(1);
               end
            end
            StDone: ;
            default: state_q <= StHold;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      car_div_ch #(
         .DIV_W      (DIV_W),
         .DIV_DEFAULT(DIV_DEFAULT)
      ) u_div (
         .clk      (clk),
         .rst      (rst),
         .ch_rst   (rst_out[i]),
         .en       (en[i]),
         .div_ratio(div_ratio[i*DIV_W +: DIV_W]),
         .div_load (div_load[i]),
         .clk_en   (clk_en[i]),
         .clk_div  (clk_div[i])
      );
   end

endmodule

// File: tb/tb_car_ctrl.sv
// Self-checking bench for car_ctrl: reset release sequence, divider ratios, enable gating,
// ratio reload timing and a reset pulse in the middle of the release sequence.
module tb_car_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [31:0] div_ratio;
  logic [3:0]  div_load;
  logic [3:0]  clk_en;
  logic [3:0]  clk_div;
  logic [3:0]  rst_out;
  logic        seq_done;
  logic [12:0] obs;

  car_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_ratio(div_ratio),
    .div_load (div_load),
    .clk_en   (clk_en),
    .clk_div  (clk_div),
    .rst_out  (rst_out),
    .seq_done (seq_done)
  );

  // Observation word: {seq_done, rst_out, clk_div, clk_en}
  assign obs = {seq_done, rst_out, clk_div, clk_en};

  localparam logic [12:0] AllMask = 13'h1FFF;
  localparam logic [12:0] RelMask = 13'h1F0F;
  localparam logic [12:0] RstVal  = 13'h0F00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] mask;
    logic [12:0] val;
  } chk_t;

  typedef struct {
    int          edge_no;
    logic [3:0]  rst_out;
    logic        seq_done;
  } rel_t;

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic [3:0]  load;
    logic [31:0] ratio;
    logic [12:0] mask;
    logic [12:0] val;
  } vec_t;

  chk_t exp_q[$];
  vec_t vecs[$];
  rel_t rel_tab[10];
  int   n_run  = 0;
  int   n_fail = 0;

  // Scoreboard: expectations pushed just after an edge, compared on the following negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      chk_t c;
      c = exp_q.pop_front();
      n_run = n_run + 1;
      if ((obs & c.mask) !== (c.val & c.mask)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %h required %h (mask %h) at %0t",
                 c.name, obs & c.mask, c.val & c.mask, c.mask, $time);
      end
    end
  end

  // Watchdog: the stimulus must finish well within this bound.
  initial begin
    #100000;
    n_run  = n_run + 1;
    n_fail = n_fail + 1;
    $display("FAIL timeout: stimulus did not complete by %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  function automatic logic [12:0] chv(input int ch, input logic ce, input logic dv);
    logic [12:0] v;
    v = (13'(dv) << (4 + ch)) | (13'(ce) << ch);
    return v;
  endfunction

  function automatic void add_vec(input string n, input logic [3:0] e, input logic [3:0] l,
                                  input logic [31:0] r, input logic [12:0] m,
                                  input logic [12:0] v);
    vec_t t;
    t.name  = n;
    t.en    = e;
    t.load  = l;
    t.ratio = r;
    t.mask  = m;
    t.val   = v;
    vecs.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string n, input logic [12:0] m, input logic [12:0] v);
    chk_t c;
    @(posedge clk);
    #1;
    c.name = n;
    c.mask = m;
    c.val  = v;
    exp_q.push_back(c);
  endtask

  // Compare with no clock edge in between: proves the asynchronous path.
  task automatic check_now(input string n, input logic [12:0] m, input logic [12:0] v);
    #1;
    n_run = n_run + 1;
    if ((obs & m) !== (v & m)) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h required %h (mask %h) at %0t",
               n, obs & m, v & m, m, $time);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_release(input string tag, input int n_edges);
    for (int k = 1; k <= n_edges; k++) begin
      int hit;
      hit = -1;
      for (int j = 0; j < 10; j++) if (rel_tab[j].edge_no == k) hit = j;
      if (hit >= 0)
        step_chk($sformatf("%s_e%0d", tag, k), RelMask,
                 {rel_tab[hit].seq_done, rel_tab[hit].rst_out, 8'h00});
      else
        tick();
    end
  endtask

  initial begin
    logic ce, dv;
    logic [31:0] r;

    rst       = 1'b1;
    en        = '0;
    div_load  = '0;
    div_ratio = '0;

    // Release timeline with defaults: channels free after edges 3, 7, 11, 15.
    rel_tab[0] = '{1,  4'hF, 1'b0};
    rel_tab[1] = '{2,  4'hF, 1'b0};
    rel_tab[2] = '{3,  4'hE, 1'b0};
    rel_tab[3] = '{6,  4'hE, 1'b0};
    rel_tab[4] = '{7,  4'hC, 1'b0};
    rel_tab[5] = '{10, 4'hC, 1'b0};
    rel_tab[6] = '{11, 4'h8, 1'b0};
    rel_tab[7] = '{14, 4'h8, 1'b0};
    rel_tab[8] = '{15, 4'h0, 1'b1};
    rel_tab[9] = '{16, 4'h0, 1'b1};

    // ch0 ratio 3; en low 5 cycles at cnt=1, resumes with the next pulse 2 edges later.
    for (int n = 1; n <= 20; n++) begin
      if (n <= 10) begin
        ce = (n % 3 == 0);
        dv = 1'((n / 3) % 2);
      end else if (n <= 15) begin
        ce = 1'b0;
        dv = 1'b1;
      end else begin
        ce = (n == 17) || (n == 20);
        dv = (n == 16) || (n == 20);
      end
      add_vec($sformatf("ch0_r3_n%0d", n), (n >= 11 && n <= 15) ? 4'b0000 : 4'b0001,
              (n == 1) ? 4'b0001 : 4'b0000, 32'h0000_0003, chv(0, 1'b1, 1'b1),
              chv(0, ce, dv));
    end

    // ch1 ratio 0 behaves as 1: enable held high, toggle every cycle.
    for (int k = 1; k <= 6; k++)
      add_vec($sformatf("ch1_r0_n%0d", k), 4'b0011, (k == 1) ? 4'b0010 : 4'b0000,
              32'h0000_0003, chv(1, 1'b1, 1'b1), chv(1, 1'b1, 1'((k % 2))));

    // ch2 ratio 4, reload 2 mid-period, then reload 3 on a wrap edge.
    dv = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      ce = (k == 4) || (k == 8) || (k == 10) || (k == 12) || (k == 14) || (k == 16) ||
           (k == 19) || (k == 22);
      if (ce) dv = ~dv;
      r = (k == 1) ? 32'h0004_0003 : (k == 6) ? 32'h0002_0003 :
          (k == 16) ? 32'h0003_0003 : 32'h0000_0003;
      add_vec($sformatf("ch2_reload_n%0d", k), 4'b0111,
              (k == 1 || k == 6 || k == 16) ? 4'b0100 : 4'b0000, r,
              chv(2, 1'b1, 1'b1), chv(2, ce, dv));
    end

    // Reset held for 5 cycles, then the release sequence.
    check_now("reset_async", AllMask, RstVal);
    for (int k = 0; k < 5; k++) step_chk($sformatf("reset_hold%0d", k), AllMask, RstVal);
    rst = 1'b0;
    check_release("rel1", 16);

    for (int i = 0; i < vecs.size(); i++) begin
      en        = vecs[i].en;
      div_load  = vecs[i].load;
      div_ratio = vecs[i].ratio;
      step_chk(vecs[i].name, vecs[i].mask, vecs[i].val);
    end
    div_load = '0;

    // Reset while dividers run clears everything without a clock edge.
    rst = 1'b1;
    check_now("rst_run_async", AllMask, RstVal);
    en = '0;
    step_chk("rst_run_hold", AllMask, RstVal);
    rst = 1'b0;
    check_release("rel2", 9);

    // One-cycle pulse while rst_out[2] is still high, then a full replay.
    rst = 1'b1;
    check_now("rst_mid_async", AllMask, RstVal);
    step_chk("rst_mid_hold", AllMask, RstVal);
    rst = 1'b0;
    check_release("rel3", 16);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
